// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state, grant and read/write encodings shared by the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - fetch/data priority decision with a saturating fetch-starvation counter
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_grant,
  output logic o_winner
);

  logic [3:0] r_starve_cnt;
  logic       w_if_wins;

  // Data normally wins; fetch takes the port once it has been passed over STARVE_MAX times.
  assign w_if_wins = i_if_req && (!i_d_req || (r_starve_cnt == 4'(STARVE_MAX)));
  assign o_winner  = w_if_wins ? GNT_IF : GNT_D;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (i_grant) begin
      if (w_if_wins) begin
        r_starve_cnt <= '0;
      end else if (i_if_req && (r_starve_cnt != 4'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory access port between instruction fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_lat_cnt;
  logic              w_grant;
  logic              w_winner;
  logic              w_lat_done;

  assign w_grant    = (r_state == IDLE) && (i_if_req || i_d_req);
  assign w_lat_done = (r_lat_cnt == 2'd0);
  assign o_busy     = (r_state != IDLE);

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .i_grant  (w_grant),
    .o_winner (w_winner)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_mem_en    = 1'b0;
    o_mem_rw    = MEM_RD;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_if_ack    = 1'b0;
    o_if_rdata  = '0;
    o_d_ack     = 1'b0;
    o_d_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        o_mem_en    = 1'b1;
        o_mem_rw    = r_we;
        o_mem_addr  = r_addr;
        o_mem_wdata = (r_we == MEM_WR) ? r_wdata : '0;
        w_state_nxt = (r_we == MEM_WR) ? DONE : WAIT;
      end
      WAIT: begin
        o_mem_addr = r_addr;
        if (w_lat_done) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (r_gnt == GNT_IF) begin
          o_if_ack   = 1'b1;
          o_if_rdata = (r_we == MEM_WR) ? '0 : r_rdata;
        end else begin
          o_d_ack   = 1'b1;
          o_d_rdata = (r_we == MEM_WR) ? '0 : r_rdata;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant so requesters may move on immediately afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt     <= GNT_IF;
      r_we      <= MEM_RD;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_gnt <= w_winner;
        if (w_winner == GNT_D) begin
          r_we    <= i_d_we;
          r_addr  <= i_d_addr;
          r_wdata <= i_d_wdata;
        end else begin
          r_we    <= MEM_RD;
          r_addr  <= i_if_addr;
          r_wdata <= '0;
        end
      end
      if (r_state == ACCESS) begin
        r_lat_cnt <= 2'(RD_LAT - 1);
      end else if ((r_state == WAIT) && !w_lat_done) begin
        r_lat_cnt <= r_lat_cnt - 2'd1;
      end
      if ((r_state == WAIT) && w_lat_done) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed table, corner sequences, random vs timeline model)
module tb_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic        a_if_ack, a_d_ack, a_mem_en, a_mem_rw, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_ack, b_d_ack, b_mem_en, b_mem_rw, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT_A), .STARVE_MAX(SMAX)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(a_if_ack), .o_if_rdata(a_if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(a_d_ack), .o_d_rdata(a_d_rdata),
    .o_mem_en(a_mem_en), .o_mem_rw(a_mem_rw), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .i_mem_rdata(a_mem_rdata), .o_busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT_B), .STARVE_MAX(SMAX)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(b_if_ack), .o_if_rdata(b_if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(b_d_ack), .o_d_rdata(b_d_rdata),
    .o_mem_en(b_mem_en), .o_mem_rw(b_mem_rw), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .i_mem_rdata(b_mem_rdata), .o_busy(b_busy)
  );

  // Memories drive valid data only on the last latency cycle, junk otherwise.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic        mem_init = 1'b0;
  int          pend_a = 0;
  int          pend_b = 0;
  logic [5:0]  paddr_a = '0;
  logic [5:0]  paddr_b = '0;
  logic [31:0] junk = '0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h8C010000 : (32'hA5000000 + 32'(i) * 32'h00010101);
  endfunction

  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= init_word(i);
      pend_a <= 0;
    end else begin
      if (a_mem_en && a_mem_rw) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
      if (a_mem_en && !a_mem_rw) begin
        pend_a  <= LAT_A;
        paddr_a <= a_mem_addr[7:2];
      end else if (pend_a != 0) begin
        pend_a <= pend_a - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 64; j++) mem_b[j] <= init_word(j);
      pend_b <= 0;
    end else begin
      if (b_mem_en && b_mem_rw) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
      if (b_mem_en && !b_mem_rw) begin
        pend_b  <= LAT_B;
        paddr_b <= b_mem_addr[7:2];
      end else if (pend_b != 0) begin
        pend_b <= pend_b - 1;
      end
    end
  end

  assign a_mem_rdata = (pend_a == 1) ? mem_a[paddr_a] : junk;
  assign b_mem_rdata = (pend_b == 1) ? mem_b[paddr_b] : junk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    repeat (n - 1) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic do_access(input string nm, input bit fetch, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    int ack_k;
    ack_k = we ? 2 : 2 + LAT_A;
    if (fetch) begin
      if_req = 1'b1;
      if_addr = addr;
    end else begin
      d_req = 1'b1;
      d_we = we;
      d_addr = addr;
      d_wdata = wdata;
    end
    chk({nm, "_idle_busy"}, a_busy, 0);
    for (int k = 1; k <= ack_k + 1; k++) begin
      @(negedge clk);
      chk({nm, "_en"}, a_mem_en, (k == 1));
      if (k == 1) begin
        chk({nm, "_rw"}, a_mem_rw, we);
        chk({nm, "_addr"}, a_mem_addr, addr);
        chk({nm, "_wdata"}, a_mem_wdata, we ? wdata : 32'h0);
        if_addr = 32'hFFFFFFF0;
        d_addr = 32'hFFFFFFE0;
        d_wdata = 32'h0BAD0BAD;
      end
      chk({nm, "_if_ack"}, a_if_ack, fetch && (k == ack_k));
      chk({nm, "_d_ack"}, a_d_ack, !fetch && (k == ack_k));
      chk({nm, "_busy"}, a_busy, (k <= ack_k));
      if (k == ack_k) begin
        chk({nm, "_rdata"}, fetch ? a_if_rdata : a_d_rdata, we ? 32'h0 : exp_rd);
        if_req = 1'b0;
        d_req = 1'b0;
      end
    end
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vt [7];
  int          order [$];
  logic [31:0] ref_mem [0:63];
  bit          m_act, m_who, m_we, e_en, e_ia, e_da, if_gnt, d_gnt;
  int          m_en_c, m_ack_c, m_free, m_scnt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          exp_order [6];

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h4,  32'h0,        32'h8C010000};
    vt[1] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
    vt[2] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vt[4] = '{1'b0, 1'b1, 32'h3C, 32'h12345678, 32'h0};
    vt[5] = '{1'b0, 1'b0, 32'h3C, 32'h0,        32'h12345678};
    vt[6] = '{1'b0, 1'b0, 32'h8,  32'h0,        init_word(2)};
    exp_order = '{1, 1, 1, 1, 0, 1};

    // Reset held with both requests high, then continuous contention.
    rst = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h4;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    mem_init = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      mem_init = 1'b0;
      chk("rst_en", a_mem_en, 0);
      chk("rst_rw", a_mem_rw, 0);
      chk("rst_addr", a_mem_addr, 0);
      chk("rst_wdata", a_mem_wdata, 0);
      chk("rst_acks", {a_if_ack, a_d_ack}, 0);
      chk("rst_if_rdata", a_if_rdata, 0);
      chk("rst_d_rdata", a_d_rdata, 0);
      chk("rst_busy", a_busy, 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("release_en", a_mem_en, 1);
        chk("release_addr", a_mem_addr, 32'h10);
      end
      chk("dual_ack", a_if_ack & a_d_ack, 0);
      if (a_if_ack) begin
        order.push_back(0);
        chk("cont_if_rdata", a_if_rdata, 32'h8C010000);
      end
      if (a_d_ack) begin
        order.push_back(1);
        chk("cont_d_rdata", a_d_rdata, init_word(4));
      end
      if (order.size() == 6) break;
    end
    if_req = 1'b0;
    d_req = 1'b0;
    chk("cont_count", order.size(), 6);
    for (int g = 0; g < order.size() && g < 6; g++) chk($sformatf("cont_grant%0d", g), order[g], exp_order[g]);

    // Long read latency on the RD_LAT=3 instance.
    @(negedge clk);
    reset_dut(2);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h20;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("lat_busy", b_busy, (k <= 5));
      chk("lat_en", b_mem_en, (k == 1));
      chk("lat_d_ack", b_d_ack, (k == 5));
      if (k >= 2 && k <= 4) chk("lat_addr_hold", b_mem_addr, 32'h20);
      if (k == 5) begin
        chk("lat_rdata", b_d_rdata, init_word(8));
        d_req = 1'b0;
      end
    end

    // Directed single accesses.
    @(negedge clk);
    reset_dut(2);
    foreach (vt[i]) do_access($sformatf("vec%0d", i), vt[i].fetch, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata);

    // Reset during WAIT abandons the access.
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_addr", a_mem_addr, 0);
    chk("midrst_en", a_mem_en, 0);
    chk("midrst_acks", {a_if_ack, a_d_ack}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_late_ack", {a_if_ack, a_d_ack}, 0);
    do_access("after_rst", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);

    // Random traffic against a cycle-timeline model.
    @(negedge clk);
    reset_dut(2);
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_act = 0; m_who = 0; m_we = 0; m_en_c = 0; m_ack_c = 0; m_free = 0; m_scnt = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    for (int c = 0; c < 3000; c++) begin
      e_en = m_act && (c == m_en_c);
      e_ia = m_act && (c == m_ack_c) && !m_who;
      e_da = m_act && (c == m_ack_c) && m_who;
      chk("rnd_en", a_mem_en, e_en);
      chk("rnd_if_ack", a_if_ack, e_ia);
      chk("rnd_d_ack", a_d_ack, e_da);
      chk("rnd_busy", a_busy, m_act && (c >= m_en_c));
      if (e_en) begin
        chk("rnd_rw", a_mem_rw, m_we);
        chk("rnd_addr", a_mem_addr, m_addr);
        chk("rnd_wdata", a_mem_wdata, m_we ? m_wdata : 32'h0);
      end
      if (m_act && c > m_en_c && c < m_ack_c) chk("rnd_addr_hold", a_mem_addr, m_addr);
      if (e_ia) chk("rnd_if_rdata", a_if_rdata, m_rdata);
      if (e_da) chk("rnd_d_rdata", a_d_rdata, m_we ? 32'h0 : m_rdata);

      if_gnt = m_act && !m_who && (c >= m_en_c);
      d_gnt  = m_act && m_who && (c >= m_en_c);
      if (m_act && c == m_ack_c) m_act = 0;

      if (e_ia) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = rnd_addr();
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1;
        if_addr = rnd_addr();
      end else if (if_gnt) begin
        if_addr = rnd_addr();
      end
      if (e_da) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = rnd_addr();
        d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = rnd_addr();
        d_wdata = $urandom;
      end else if (d_gnt) begin
        d_we = 1'($urandom_range(0, 1));
        d_addr = rnd_addr();
        d_wdata = $urandom;
      end

      if (!m_act && c >= m_free && (if_req || d_req)) begin
        m_who = !(if_req && (!d_req || m_scnt == SMAX));
        if (!m_who) begin
          m_scnt = 0;
          m_we = 0;
          m_addr = if_addr;
          m_wdata = '0;
        end else begin
          if (if_req && m_scnt < SMAX) m_scnt++;
          m_we = d_we;
          m_addr = d_addr;
          m_wdata = d_wdata;
        end
        m_rdata = ref_mem[m_addr[7:2]];
        if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
        m_en_c = c + 1;
        m_ack_c = c + 2 + (m_we ? 0 : LAT_A);
        m_free = m_ack_c + 1;
        m_act = 1;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
